mem_bus_ctrl: RTL and testbench

//  Sequences MEM-stage loads/stores onto a single-port data bus with a req/ack handshake.

---
 rtl/mem_bus_ctrl_if.sv | 46 ++++
 rtl/mem_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_ctrl_if
//  Purpose  : Groups the MEM-stage request, pipeline status and data-bus
//             handshake signals of mem_bus_ctrl. The controller is the bus
//             master; the pipeline/RAM side is the slave view.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_bus_ctrl_if;
    // MEM-stage request
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_sign_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    // Pipeline status / load return
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        align_err_o;
    logic        bus_err_o;
    // Data bus
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        input  mem_req_i, mem_we_i, mem_size_i, mem_sign_i, mem_addr_i, mem_wdata_i,
        input  bus_ack_i, bus_rdata_i,
        output stall_o, rdata_o, rdata_valid_o, align_err_o, bus_err_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
    );

    modport slave (
        output mem_req_i, mem_we_i, mem_size_i, mem_sign_i, mem_addr_i, mem_wdata_i,
        output bus_ack_i, bus_rdata_i,
        input  stall_o, rdata_o, rdata_valid_o, align_err_o, bus_err_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_ctrl
//  Purpose  : Sequences MEM-stage loads/stores onto a single-port req/ack data
//             bus, stalls the pipeline per access, extends load data, and
//             flags misaligned accesses and bus timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_bus_ctrl_if.master mbus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_sign;

    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_align_err;
    logic        r_bus_err;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // Reserved size 2'b11 behaves as a word.
    assign w_is_half    = (mbus.mem_size_i == 2'b01);
    assign w_is_word    = mbus.mem_size_i[1];
    assign w_misaligned = (w_is_half & mbus.mem_addr_i[0]) |
                          (w_is_word & (mbus.mem_addr_i[1:0] != 2'b00));
    assign w_start      = (r_state == ST_IDLE) & mbus.mem_req_i & ~w_misaligned;
    assign w_timeout    = (r_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mbus.mem_wdata_i;
        case (mbus.mem_size_i)
            2'b00: begin
                w_be    = 4'b1000 >> mbus.mem_addr_i[1:0];
                w_wdata = {4{mbus.mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = mbus.mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mbus.mem_wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mbus.mem_wdata_i;
            end
        endcase
    end

    // Big-endian lane selection: offset 0 lives in bits [31:24].
    always_comb begin
        w_ld_byte = mbus.bus_rdata_i[7:0];
        case (r_off)
            2'd0:    w_ld_byte = mbus.bus_rdata_i[31:24];
            2'd1:    w_ld_byte = mbus.bus_rdata_i[23:16];
            2'd2:    w_ld_byte = mbus.bus_rdata_i[15:8];
            default: w_ld_byte = mbus.bus_rdata_i[7:0];
        endcase
        w_ld_half = r_off[1] ? mbus.bus_rdata_i[15:0] : mbus.bus_rdata_i[31:16];
        w_ld_data = mbus.bus_rdata_i;
        case (r_size)
            2'b00:   w_ld_data = {{24{r_sign & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{r_sign & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = mbus.bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_off         <= 2'b00;
            r_sign        <= 1'b0;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
            r_align_err   <= 1'b0;
            r_bus_err     <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'd0;
            r_bus_be      <= 4'b0000;
            r_bus_wdata   <= 32'd0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_align_err   <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (mbus.mem_req_i) begin
                        if (w_misaligned) begin
                            r_align_err <= 1'b1;
                        end else begin
                            r_we        <= mbus.mem_we_i;
                            r_size      <= mbus.mem_size_i;
                            r_sign      <= mbus.mem_sign_i;
                            r_off       <= mbus.mem_addr_i[1:0];
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mbus.mem_we_i;
                            r_bus_addr  <= {mbus.mem_addr_i[31:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    // An ack on the final allowed cycle still completes normally.
                    if (mbus.bus_ack_i) begin
                        r_bus_req     <= 1'b0;
                        r_rdata_valid <= ~r_we;
                        if (!r_we) begin
                            r_rdata <= w_ld_data;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_req     <= 1'b0;
                        r_bus_err     <= 1'b1;
                        r_rdata_valid <= ~r_we;
                        r_rdata       <= 32'd0;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mbus.stall_o       = w_start | (r_state == ST_REQ);
    assign mbus.rdata_o       = r_rdata;
    assign mbus.rdata_valid_o = r_rdata_valid;
    assign mbus.align_err_o   = r_align_err;
    assign mbus.bus_err_o     = r_bus_err;
    assign mbus.bus_req_o     = r_bus_req;
    assign mbus.bus_we_o      = r_bus_we;
    assign mbus.bus_addr_o    = r_bus_addr;
    assign mbus.bus_be_o      = r_bus_be;
    assign mbus.bus_wdata_o   = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_ctrl
//  Purpose  : Self-checking bench for mem_bus_ctrl: directed scenarios plus
//             randomized accesses compared against a byte-arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int unsigned c_TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   req_rises = 0;
    logic r_prev_req = 1'b0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if bif();

    mem_bus_ctrl #(.TIMEOUT(c_TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .mbus (bif)
    );

    always @(negedge clk) begin
        if (bif.bus_req_o && !r_prev_req) req_rises++;
        r_prev_req <= bif.bus_req_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] byte_mask(input int n);
        return (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 64'd1);
    endfunction

    function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int n = nbytes(size);
        int off = int'(addr % 4);
        return 4'(((1 << n) - 1) << (4 - n - off));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        int n = nbytes(size);
        logic [31:0] rep;
        rep = (n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'h0000_0001;
        return (w & byte_mask(n)) * rep;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                               input logic sign, input logic [31:0] rd);
        int n = nbytes(size);
        int sh = (4 - n - int'(addr % 4)) * 8;
        logic [31:0] v;
        v = (rd >> sh) & byte_mask(n);
        if (n < 4 && sign && v[8 * n - 1]) v = v | ~byte_mask(n);
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bif.mem_req_i   = 1'b1;
        bif.mem_we_i    = we;
        bif.mem_size_i  = size;
        bif.mem_sign_i  = sign;
        bif.mem_addr_i  = addr;
        bif.mem_wdata_i = wdata;
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = $urandom;
    endtask

    // One complete access; for aligned ones the ack comes after `waits` wait cycles.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input logic [31:0] rd);
        @(negedge clk);
        drive_req(we, size, sign, addr, wdata);
        #1;
        if (is_misaligned(size, addr)) begin
            chk("mis_stall", {31'd0, bif.stall_o}, 32'd0);
            @(negedge clk);
            bif.mem_req_i = 1'b0;
            #1;
            chk("mis_align_err", {31'd0, bif.align_err_o}, 32'd1);
            chk("mis_bus_req",   {31'd0, bif.bus_req_o},   32'd0);
            chk("mis_stall2",    {31'd0, bif.stall_o},     32'd0);
            chk("mis_valid",     {31'd0, bif.rdata_valid_o}, 32'd0);
            return;
        end
        chk("idle_stall", {31'd0, bif.stall_o},   32'd1);
        chk("idle_req",   {31'd0, bif.bus_req_o}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            bif.bus_ack_i   = (i == waits);
            bif.bus_rdata_i = (i == waits) ? rd : $urandom;
            #1;
            chk("req_req",   {31'd0, bif.bus_req_o}, 32'd1);
            chk("req_stall", {31'd0, bif.stall_o},   32'd1);
            chk("req_we",    {31'd0, bif.bus_we_o},  {31'd0, we});
            chk("req_addr",  bif.bus_addr_o, {addr[31:2], 2'b00});
            chk("req_be",    {28'd0, bif.bus_be_o}, {28'd0, model_be(size, addr)});
            if (we) chk("req_wdata", bif.bus_wdata_o, model_wdata(size, wdata));
        end
        @(negedge clk);
        bif.bus_ack_i   = 1'($urandom_range(0, 1));
        bif.bus_rdata_i = $urandom;
        #1;
        chk("done_stall", {31'd0, bif.stall_o},       32'd0);
        chk("done_req",   {31'd0, bif.bus_req_o},     32'd0);
        chk("done_valid", {31'd0, bif.rdata_valid_o}, {31'd0, ~we});
        chk("done_err",   {31'd0, bif.bus_err_o},     32'd0);
        if (!we) chk("done_rdata", bif.rdata_o, model_load(size, addr, sign, rd));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bif.mem_req_i   = 1'b0;
        bif.bus_ack_i   = 1'($urandom_range(0, 1));
        bif.bus_rdata_i = $urandom;
        #1;
        chk("idle_req2",  {31'd0, bif.bus_req_o},     32'd0);
        chk("idle_stall2",{31'd0, bif.stall_o},       32'd0);
        chk("idle_valid", {31'd0, bif.rdata_valid_o}, 32'd0);
        chk("idle_err",   {31'd0, bif.bus_err_o},     32'd0);
        chk("idle_aerr",  {31'd0, bif.align_err_o},   32'd0);
    endtask

    initial begin
        logic [1:0]  size;
        logic [31:0] addr;
        int          rises0;

        rst = 1'b1;
        bif.mem_req_i = 1'b0; bif.mem_we_i = 1'b0; bif.mem_size_i = 2'b00;
        bif.mem_sign_i = 1'b0; bif.mem_addr_i = 32'd0; bif.mem_wdata_i = 32'd0;
        bif.bus_ack_i = 1'b0; bif.bus_rdata_i = 32'd0;
        @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, bif.stall_o},   32'd0);
        chk("rst_req",   {31'd0, bif.bus_req_o}, 32'd0);
        chk("rst_valid", {31'd0, bif.rdata_valid_o}, 32'd0);
        chk("rst_rdata", bif.rdata_o,  32'd0);
        chk("rst_addr",  bif.bus_addr_o, 32'd0);
        chk("rst_be",    {28'd0, bif.bus_be_o}, 32'd0);
        chk("rst_wdata", bif.bus_wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Word load, ack after three waits (four REQ cycles, last allowed one)
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF);
        idle_cycle();
        // Byte loads at offset 3, signed and unsigned
        do_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 0, 32'h0000_00F0);
        chk("t2_be", {28'd0, bif.bus_be_o}, 32'h0000_0001);
        chk("t2_sext", bif.rdata_o, 32'hFFFF_FFF0);
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 0, 32'h0000_00F0);
        chk("t2_zext", bif.rdata_o, 32'h0000_00F0);
        idle_cycle();
        // Half store, zero wait
        do_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 0, 32'd0);
        chk("t3_wdata", bif.bus_wdata_o, 32'hABCD_ABCD);
        idle_cycle();
        // Misaligned word
        rises0 = req_rises;
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 0, 32'd0);
        idle_cycle();
        chk("t4_no_req", 32'(req_rises - rises0), 32'd0);

        // Timeout: no ack for TIMEOUT REQ cycles
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0);
        for (int i = 0; i < int'(c_TO); i++) begin
            @(negedge clk);
            bif.bus_ack_i = 1'b0;
            #1;
            chk("to_req", {31'd0, bif.bus_req_o}, 32'd1);
            chk("to_stall", {31'd0, bif.stall_o}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("to_req_drop", {31'd0, bif.bus_req_o}, 32'd0);
        chk("to_bus_err",  {31'd0, bif.bus_err_o}, 32'd1);
        chk("to_stall_rel",{31'd0, bif.stall_o},   32'd0);
        chk("to_valid",    {31'd0, bif.rdata_valid_o}, 32'd1);
        chk("to_rdata",    bif.rdata_o, 32'd0);
        idle_cycle();

        // Reset in the middle of REQ
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_5678);
        repeat (2) @(negedge clk);
        #1;
        chk("mr_req_before", {31'd0, bif.bus_req_o}, 32'd1);
        rst = 1'b1;
        bif.mem_req_i = 1'b0;
        #1;
        chk("mr_req",   {31'd0, bif.bus_req_o}, 32'd0);
        chk("mr_stall", {31'd0, bif.stall_o},   32'd0);
        chk("mr_err",   {31'd0, bif.bus_err_o}, 32'd0);
        chk("mr_addr",  bif.bus_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Back-to-back loads: one request each, never re-issued from DONE
        rises0 = req_rises;
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_0500, 32'd0, 1, 32'h8001_7FFF);
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_0502, 32'd0, 0, 32'h8001_7FFF);
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0501, 32'd0, 2, 32'h1122_3344);
        idle_cycle();
        chk("b2b_rises", 32'(req_rises - rises0), 32'd3);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
            do_access(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
                      $urandom, int'($urandom_range(0, c_TO - 1)), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
